lcd_cmd_sequencer: RTL and testbench

Upstream command stage for LCD_CTRL. Buffers 4-bit LCD commands pushed by a host or test source in a small FIFO. Forwards them to LCD_CTRL over its cmd/cmd_valid/busy handshake. After forwarding a WRITE (opcode 0), it holds further issue until LCD_CTRL pulses done. Illegal opcodes are filtered at entry.

---
 rtl/lcd_cmd_pkg.sv | 29 ++
 rtl/lcd_cmd_fifo_mem.sv | 61 ++++++
 rtl/lcd_cmd_sequencer.sv | 104 ++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_cmd_pkg.sv
// Shared opcode map, state encoding and legality test for the LCD command sequencer.
package lcd_cmd_pkg;

  localparam int CMD_W = 4;

  localparam logic [CMD_W-1:0] OP_WRITE      = 4'h0;
  localparam logic [CMD_W-1:0] OP_SHIFT_U    = 4'h1;
  localparam logic [CMD_W-1:0] OP_SHIFT_D    = 4'h2;
  localparam logic [CMD_W-1:0] OP_SHIFT_L    = 4'h3;
  localparam logic [CMD_W-1:0] OP_SHIFT_R    = 4'h4;
  localparam logic [CMD_W-1:0] OP_MAX        = 4'h5;
  localparam logic [CMD_W-1:0] OP_MIN        = 4'h6;
  localparam logic [CMD_W-1:0] OP_AVG        = 4'h7;
  localparam logic [CMD_W-1:0] OP_CCW        = 4'h8;
  localparam logic [CMD_W-1:0] OP_CW         = 4'h9;
  localparam logic [CMD_W-1:0] OP_MIRROR_X   = 4'hA;
  localparam logic [CMD_W-1:0] OP_MIRROR_Y   = 4'hB;
  localparam logic [CMD_W-1:0] OP_LAST_LEGAL = 4'hB;

  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_WAIT_DONE = 1'b1
  } state_t;

  function automatic logic op_is_legal(input logic [CMD_W-1:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo_mem.sv
// Command FIFO storage: DEPTH x CMD_W registers, wrapping pointers, occupancy count.
// Flush has priority over read and write; head is read straight from storage.
module lcd_cmd_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int CMD_W = 4,
  parameter int LVL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [CMD_W-1:0] wr_dat,
  input  logic             rd_en,
  input  logic             flush,
  output logic [CMD_W-1:0] rd_dat,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_wr;
  logic             w_rd;

  assign full   = (r_level == LVL_W'(DEPTH));
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign rd_dat = r_mem[r_rd_ptr];
  assign w_wr   = wr_en & ~full;
  assign w_rd   = rd_en & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= wr_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Filters host commands into a FIFO and issues them to LCD_CTRL, stalling after WRITE until done.
// Optional accept counter enabled by LCD_CMDQ_STAT_EN; otherwise issued_cnt is tied to 0.
module lcd_cmd_sequencer
  import lcd_cmd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CMD_W = 4,
  parameter int LVL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CMD_W-1:0] in_cmd,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic             busy,
  input  logic             done,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_valid,
  output logic             wait_done,
  output logic [LVL_W-1:0] level,
  output logic             illegal_err,
  input  logic             err_clr,
  output logic [7:0]       issued_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_illegal_err;
  logic             w_full;
  logic             w_empty;
  logic [CMD_W-1:0] w_head;
  logic             w_hs;
  logic             w_legal;
  logic             w_push;
  logic             w_accept;

  assign in_ready = ~w_full & ~flush;
  assign w_hs     = in_valid & in_ready;
  assign w_legal  = op_is_legal(in_cmd);
  assign w_push   = w_hs & w_legal;
  // Flush cancels a same-cycle accept: nothing pops, counts or changes state.
  assign w_accept = cmd_valid & ~busy & ~flush;
  assign cmd      = w_head;

  lcd_cmd_fifo_mem #(
    .DEPTH (DEPTH),
    .CMD_W (CMD_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (w_push),
    .wr_dat (in_cmd),
    .rd_en  (w_accept),
    .flush  (flush),
    .rd_dat (w_head),
    .full   (w_full),
    .empty  (w_empty),
    .level  (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_valid   = 1'b0;
    wait_done   = 1'b0;
    case (r_state)
      ST_RUN: begin
        cmd_valid = ~w_empty;
        if (~w_empty && ~busy && ~flush && (w_head == OP_WRITE)) w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        wait_done = 1'b1;
        if (done) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // A new illegal push outranks a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_illegal_err <= 1'b0;
    else if (w_hs & ~w_legal) r_illegal_err <= 1'b1;
    else if (err_clr)         r_illegal_err <= 1'b0;
  end
  assign illegal_err = r_illegal_err;

`ifdef LCD_CMDQ_STAT_EN
  logic [7:0] r_issued_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_issued_cnt <= '0;
    else if (w_accept && r_issued_cnt != 8'hFF) r_issued_cnt <= r_issued_cnt + 1'b1;
  end
  assign issued_cnt = r_issued_cnt;
`else
  assign issued_cnt = '0;
`endif

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_lcd_cmd_sequencer;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] in_cmd = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic       busy = 1'b0;
  logic       done = 1'b0;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       wait_done;
  logic [3:0] level;
  logic       illegal_err;
  logic       err_clr = 1'b0;
  logic [7:0] issued_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of stored commands, a waiting flag, sticky error, accept count.
  int m_q[$];
  bit m_wait = 0;
  bit m_err  = 0;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  lcd_cmd_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .in_cmd      (in_cmd),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .wait_done   (wait_done),
    .level       (level),
    .illegal_err (illegal_err),
    .err_clr     (err_clr),
    .issued_cnt  (issued_cnt)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_cnt();
`ifdef LCD_CMDQ_STAT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic check_outputs();
    bit exp_valid;
    exp_valid = (m_q.size() > 0) && !m_wait;
    check_eq("level", int'(level), m_q.size());
    check_eq("cmd_valid", int'(cmd_valid), int'(exp_valid));
    check_eq("wait_done", int'(wait_done), int'(m_wait));
    check_eq("in_ready", int'(in_ready), int'((m_q.size() < DEPTH) && !flush));
    check_eq("illegal_err", int'(illegal_err), int'(m_err));
    check_eq("issued_cnt", int'(issued_cnt), exp_cnt());
    if (m_q.size() > 0) check_eq("cmd", int'(cmd), m_q[0]);
  endtask

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_edge();
    bit rdy, exp_valid, accept, hs, legal;
    int op;
    rdy       = (m_q.size() < DEPTH) && !flush;
    exp_valid = (m_q.size() > 0) && !m_wait;
    accept    = exp_valid && !busy && !flush;
    hs        = in_valid && rdy;
    legal     = (in_cmd <= 4'd11);
    op        = -1;
    if (flush) m_q.delete();
    else begin
      if (accept) op = m_q.pop_front();
      if (hs && legal) m_q.push_back(int'(in_cmd));
    end
    if (accept) begin
      if (m_cnt < 255) m_cnt++;
      if (op == 0) m_wait = 1;
    end else if (m_wait && done) m_wait = 0;
    if (hs && !legal) m_err = 1;
    else if (err_clr) m_err = 0;
  endtask

  // Called just after a falling edge: drive, check, model the coming rising edge.
  task automatic cyc(input bit v, input int c, input bit f, input bit b, input bit d, input bit ec);
    in_valid = v;
    in_cmd   = 4'(c);
    flush    = f;
    busy     = b;
    done     = d;
    err_clr  = ec;
    #1;
    check_outputs();
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit b);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, b, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 0; flush = 0; busy = 0; done = 0; err_clr = 0; in_cmd = '0;
    #1;
    check_eq("rst_cmd", int'(cmd), 0);
    check_eq("rst_cmd_valid", int'(cmd_valid), 0);
    check_eq("rst_wait_done", int'(wait_done), 0);
    check_eq("rst_level", int'(level), 0);
    check_eq("rst_illegal_err", int'(illegal_err), 0);
    check_eq("rst_issued_cnt", int'(issued_cnt), 0);
    check_eq("rst_in_ready", int'(in_ready), 1);
    m_q.delete();
    m_wait = 0;
    m_err  = 0;
    m_cnt  = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // In-order issue, first cmd_valid one cycle after push.
    cyc(1, 3, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 7, 0, 0, 0, 0);
    idle(4, 0);

    // WRITE stalls the queue until done.
    cyc(1, 5, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 9, 0, 1, 0, 0);
    idle(2, 0);
    idle(20, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(3, 0);

    // Overfill while busy, then drain across the pointer wrap.
    for (int i = 0; i < 9; i++) cyc(1, i + 1, 0, 1, 0, 0);
    idle(3, 1);
    idle(10, 0);

    // Illegal opcode filtering and sticky error.
    cyc(1, 13, 0, 0, 0, 0);
    idle(1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    idle(1, 0);
    cyc(1, 14, 0, 0, 0, 1);
    idle(1, 0);

    // Flush beats same-cycle push and accept.
    for (int i = 0; i < 4; i++) cyc(1, 4 + i, 0, 1, 0, 0);
    cyc(1, 2, 1, 0, 0, 0);
    idle(3, 0);

    // Long accept stream for counter saturation.
    for (int i = 0; i < 320; i++) cyc(1, $urandom_range(1, 11), 0, 0, 0, 0);
    idle(3, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, 15), ($urandom_range(0, 15) == 0),
          $urandom_range(0, 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));

    // Reset in the middle of queued traffic.
    for (int i = 0; i < 5; i++) cyc(1, $urandom_range(1, 11), 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    do_reset();
    idle(2, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
